lfsr_stream: RTL
================

# lfsr_stream

Parametrised Fibonacci LFSR word generator, the next generation of the team's single-bit LFSR. It keeps the same feedback convention but adds run-time tap and seed loading, packs WBITS serial output bits into one word, and delivers each word over a valid/ready handshake with back-pressure. Optional all-zero seed protection is compiled in by macro. It sits between a pseudo-random consumer (scrambler, BIST pattern source, test stimulus) and the control logic that seeds it.

## Interface
- NBITS, 8, LFSR state width; legal range 2..64.
- WBITS, 4, output word width in bits; legal range 1..NBITS.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset: asserting it low resets immediately; deassertion is synchronous to clk.
- load  in  1  one-cycle request to capture seed and tap; highest priority.
- seed  in  NBITS  initial state; sampled only when load=1.
- tap  in  NBITS  feedback mask; sampled into tap_q only when load=1; bit 0 is ignored.
- en  in  1  step enable; when 0, the state and bit counter hold.
- out_val  out  1  out_data holds a complete word.
- out_rdy  in  1  consumer accepts the word.
- out_data  out  WBITS  packed word; bit k is the k-th generated bit.
- lockup  out  1  sticky flag: the last load had an all-zero seed (macro only).

## Operation
- Reset values: state=0, tap_q=0, bit counter=0, out_val=0, out_data=0, lockup=0, FSM=IDLE.
- Step function:
  - fb = q[0] XOR (XOR of q[i] for every i in 1..NBITS-1 with tap_q[i]=1).
  - Next state = {fb, q[NBITS-1:1]}.
  - The emitted bit is q[0] before the step.
- FSM states:
  - IDLE: no seed has been loaded; steps are ignored; out_val=0.
  - FILL: each cycle with en=1 performs one step and writes the emitted bit to out_data[cnt], then cnt increments. On the step with cnt=WBITS-1: cnt is set to 0, out_val is set to 1, and the FSM moves to FULL.
  - FULL: out_val=1 and out_data is stable. The LFSR does not step unless a handshake occurs in the same cycle.
- Handshake (FULL with out_val & out_rdy):
  - The word is consumed.
  - If en=1 in that cycle, one step also occurs and its bit becomes out_data[0] of the next word. cnt becomes 1 and the FSM goes to FILL. If WBITS=1, the FSM stays in FULL with the new word instead.
  - If en=0, cnt becomes 0, the FSM goes to FILL, and out_val drops next cycle.
- load (from any state):
  - state is set to seed and tap_q to tap; cnt is set to 0; out_val is set to 0.
  - A pending or partial word is discarded; out_data is not cleared.
  - The FSM goes to FILL.
  - Any en or handshake in the same cycle is ignored; the word is not counted as consumed.
- The step map is invertible, so a nonzero state never reaches zero. Zero arises only from a zero seed.

## Timing
- If load is in cycle t and en=1 continuously, out_val is first high in cycle t+1+WBITS.
- Sustained throughput with out_rdy=1 and en=1 is one word every WBITS cycles.
- out_data and out_val are registered; there is no combinational path from out_rdy to out_val.
- rst asserted mid-word clears everything asynchronously. After deassertion the FSM is in IDLE until the next load.
- en=0 while in FULL does not drop out_val.

## Configuration
- LFSR_STREAM_LOCKUP_EN defined:
  - A load with seed=0 loads state=1 instead and sets lockup=1.
  - A load with a nonzero seed clears lockup.
- LFSR_STREAM_LOCKUP_EN undefined:
  - A zero seed is loaded as-is, and the generator then emits all-zero words forever.
  - lockup is tied to 0.

## Test plan
- Reset: rst low mid-word, then high -> out_val=0, out_data=0, lockup=0. With en=1 and no load, out_val stays 0 for 20 cycles.
- NBITS=8, WBITS=4, seed=8'h01, tap=8'h00, en=1, out_rdy=1 -> first word 4'h1 in cycle t+5, then alternating 4'h0, 4'h1, one word every 4 cycles.
- seed=8'h03, tap=8'h02 -> first word 4'h3; state after 4 steps is 8'h20.
- Back-pressure: out_rdy=0 for 10 cycles after out_val -> out_val and out_data hold. The handshake then delivers the next word 4 cycles later.
- load asserted with cnt=2 and out_rdy=1 in the same cycle -> the partial word is discarded and no word is consumed. The new seed's first word arrives 5 cycles later.
- Zero-seed load with the macro defined -> lockup=1 and the sequence matches seed=8'h01. Without the macro -> words are 4'h0 forever and lockup=0.

Source files
------------

// File: rtl/lfsr_stream.sv
// rtl/lfsr_stream.sv - Fibonacci LFSR word generator with valid/ready output.
// Define LFSR_STREAM_LOCKUP_EN to replace zero seeds with 1 and flag them on lockup.
module lfsr_stream #(
  parameter int NBITS = 8,
  parameter int WBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NBITS-1:0] seed,
  input  logic [NBITS-1:0] tap,
  input  logic             en,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WBITS-1:0] out_data,
  output logic             lockup
);

  localparam int CW = (WBITS > 1) ? $clog2(WBITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WBITS - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t           st, st_n;
  logic [NBITS-1:0] q, q_n, q_step, seed_eff;
  logic [NBITS-1:1] tap_q, tap_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             val_n;
  logic [WBITS-1:0] data_n;
  logic             fb;
  logic             tap0_unused;

  // Bit 0 always feeds back, so its mask bit carries no information.
  assign tap0_unused = tap[0];
  assign fb          = q[0] ^ (^(q[NBITS-1:1] & tap_q));
  assign q_step      = {fb, q[NBITS-1:1]};

`ifdef LFSR_STREAM_LOCKUP_EN
  logic lock_q;
  assign seed_eff = (seed == '0) ? NBITS'(1) : seed;
  assign lockup   = lock_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 1'b0;
    end else if (load) begin
      lock_q <= (seed == '0);
    end
  end
`else
  assign seed_eff = seed;
  assign lockup   = 1'b0;
`endif

  always_comb begin
    st_n   = st;
    q_n    = q;
    tap_n  = tap_q;
    cnt_n  = cnt;
    val_n  = out_val;
    data_n = out_data;
    if (load) begin
      q_n   = seed_eff;
      tap_n = tap[NBITS-1:1];
      cnt_n = '0;
      val_n = 1'b0;
      st_n  = FILL;
    end else begin
      unique case (st)
        IDLE: ;
        FILL: begin
          if (en) begin
            q_n         = q_step;
            data_n[cnt] = q[0];
            if (cnt == CNT_LAST) begin
              cnt_n = '0;
              val_n = 1'b1;
              st_n  = FULL;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
        FULL: begin
          if (out_rdy) begin
            if (en) begin
              q_n       = q_step;
              data_n[0] = q[0];
              if (WBITS == 1) begin
                cnt_n = '0;
              end else begin
                cnt_n = CW'(1);
                val_n = 1'b0;
                st_n  = FILL;
              end
            end else begin
              cnt_n = '0;
              val_n = 1'b0;
              st_n  = FILL;
            end
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      q        <= '0;
      tap_q    <= '0;
      cnt      <= '0;
      out_val  <= 1'b0;
      out_data <= '0;
    end else begin
      st       <= st_n;
      q        <= q_n;
      tap_q    <= tap_n;
      cnt      <= cnt_n;
      out_val  <= val_n;
      out_data <= data_n;
    end
  end

endmodule
